// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA transfer engine.
// Chunk sizing helper keeps the buffer depth in one place.
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        DONE
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam int unsigned BUF_DEPTH     = 4;
    localparam int unsigned PTR_W         = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W         = $clog2(BUF_DEPTH) + 1;

    function automatic logic [CNT_W-1:0] chunk_len_of(input logic [15:0] remaining);
        if (remaining >= 16'(BUF_DEPTH))
            return CNT_W'(BUF_DEPTH);
        else
            return remaining[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/dmac_xfer_buf.sv
// Chunk staging buffer: read data is pushed in order, then popped for writes.
// rd_data always presents the entry at the read pointer.
module dmac_xfer_buf
    import dmac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    input  logic             rd_en,
    output logic [31:0]      rd_data,
    output logic [CNT_W-1:0] count
);

    logic [31:0]      mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dmac_xfer_engine.sv
// Single-channel AHB memory-to-memory mover: reads up to four words into a
// staging buffer, then writes them out, repeating until the count is exhausted.
module dmac_xfer_engine
    import dmac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Channel_en,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] xfer_cnt,
    input  logic        src_inc,
    input  logic        dst_inc,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        irq,
    output logic        xfer_err
);

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic             s_inc;
    logic             d_inc;
    logic [15:0]      remaining;
    logic [CNT_W-1:0] chunk_cnt;

    logic [31:0]      src_step;
    logic [31:0]      dst_step;
    logic [15:0]      remaining_dec;
    logic             data_ok;
    logic             bus_err;
    logic             buf_wr;
    logic             buf_rd;
    logic             buf_clr;
    logic [31:0]      buf_rd_data;
    logic [CNT_W-1:0] buf_count;

    always_comb begin
        src_step      = s_inc ? src_ptr + 32'd4 : src_ptr;
        dst_step      = d_inc ? dst_ptr + 32'd4 : dst_ptr;
        remaining_dec = remaining - 16'd1;
        data_ok       = HREADY && !HRESP;
        bus_err       = HREADY && HRESP;
        buf_wr        = (state == RD_DATA) && data_ok;
        buf_rd        = (state == WR_DATA) && data_ok;
        buf_clr       = (state == IDLE) || (state == DONE);
    end

    assign HSIZE = HSIZE_WORD;

    dmac_xfer_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (HRDATA),
        .rd_en   (buf_rd),
        .rd_data (buf_rd_data),
        .count   (buf_count)
    );

    // Bus outputs are registered alongside each transition, so they always
    // reflect the state being entered and the already-stepped address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            s_inc     <= 1'b0;
            d_inc     <= 1'b0;
            remaining <= '0;
            chunk_cnt <= '0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            busy      <= 1'b0;
            irq       <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (Channel_en) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        s_inc     <= src_inc;
                        d_inc     <= dst_inc;
                        remaining <= xfer_cnt;
                        chunk_cnt <= chunk_len_of(xfer_cnt);
                        xfer_err  <= 1'b0;
                        busy      <= 1'b1;
                        if (xfer_cnt == 16'd0) begin
                            state <= DONE;
                        end else begin
                            state  <= RD_ADDR;
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= 1'b0;
                            HADDR  <= src_addr;
                        end
                    end
                end
                RD_ADDR: begin
                    if (HREADY) begin
                        state  <= RD_DATA;
                        HTRANS <= HTRANS_IDLE;
                    end
                end
                RD_DATA: begin
                    if (bus_err) begin
                        xfer_err <= 1'b1;
                        state    <= DONE;
                        HTRANS   <= HTRANS_IDLE;
                        HWRITE   <= 1'b0;
                    end else if (HREADY) begin
                        src_ptr   <= src_step;
                        chunk_cnt <= chunk_cnt - 1'b1;
                        HTRANS    <= HTRANS_NONSEQ;
                        if (chunk_cnt == CNT_W'(1)) begin
                            state  <= WR_ADDR;
                            HWRITE <= 1'b1;
                            HADDR  <= dst_ptr;
                        end else begin
                            state <= RD_ADDR;
                            HADDR <= src_step;
                        end
                    end
                end
                WR_ADDR: begin
                    if (HREADY) begin
                        state  <= WR_DATA;
                        HTRANS <= HTRANS_IDLE;
                        HWDATA <= buf_rd_data;
                    end
                end
                WR_DATA: begin
                    if (bus_err) begin
                        xfer_err <= 1'b1;
                        state    <= DONE;
                        HTRANS   <= HTRANS_IDLE;
                        HWRITE   <= 1'b0;
                    end else if (HREADY) begin
                        dst_ptr   <= dst_step;
                        remaining <= remaining_dec;
                        // The buffer occupancy doubles as the write-side chunk count.
                        if (buf_count == CNT_W'(1)) begin
                            HWRITE <= 1'b0;
                            if (remaining_dec != 16'd0) begin
                                state     <= RD_ADDR;
                                chunk_cnt <= chunk_len_of(remaining_dec);
                                HTRANS    <= HTRANS_NONSEQ;
                                HADDR     <= src_ptr;
                            end else begin
                                state  <= DONE;
                                HTRANS <= HTRANS_IDLE;
                            end
                        end else begin
                            state  <= WR_ADDR;
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= dst_step;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    irq       <= 1'b1;
                    busy      <= 1'b0;
                    remaining <= '0;
                    chunk_cnt <= '0;
                    HTRANS    <= HTRANS_IDLE;
                    HWRITE    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    HTRANS <= HTRANS_IDLE;
                    HWRITE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_xfer_engine.sv
// Bench for dmac_xfer_engine: an AHB slave model feeds address-derived data and
// every observed transfer is compared against a chunked reference of the move.
module tb_dmac_xfer_engine;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        Channel_en;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] xfer_cnt;
    logic        src_inc;
    logic        dst_inc;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic        irq;
    logic        xfer_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] seed;
    op_t         act_q[$];
    op_t         exp_q[$];

    bit          data_pending = 1'b0;
    logic [31:0] d_addr;
    logic        d_write;
    int          stall_left = 0;
    bit          stall_armed = 1'b0;
    logic [31:0] stall_data;
    int          rd_seen = 0;
    int          wr_seen = 0;
    int          err_read_idx = -1;
    int          stall_wr_idx = -1;
    int          stall_len = 0;

    dmac_xfer_engine dut (
        .clk        (clk),
        .rst        (rst),
        .Channel_en (Channel_en),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .xfer_cnt   (xfer_cnt),
        .src_inc    (src_inc),
        .dst_inc    (dst_inc),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .busy       (busy),
        .irq        (irq),
        .xfer_err   (xfer_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: decides HREADY/HRESP for the coming edge and logs completed beats.
    always @(negedge clk) begin
        if (!rst) begin
            data_pending = 1'b0;
            stall_left   = 0;
            HREADY       = 1'b1;
            HRESP        = 1'b0;
            HRDATA       = '0;
        end else if (data_pending) begin
            HRDATA = d_write ? $urandom : mem_word(d_addr);
            if (stall_left > 0) begin
                if (stall_armed) begin
                    check("stall_hwdata", {32'd0, HWDATA}, {32'd0, stall_data});
                    check("stall_htrans", {62'd0, HTRANS}, 64'd0);
                    check("stall_busy", {63'd0, busy}, 64'd1);
                end else begin
                    stall_data  = HWDATA;
                    stall_armed = 1'b1;
                end
                HREADY = 1'b0;
                HRESP  = 1'b0;
                stall_left--;
            end else begin
                op_t o;
                HREADY = 1'b1;
                if (!d_write && rd_seen == err_read_idx) begin
                    HRESP = 1'b1;
                end else begin
                    HRESP  = 1'b0;
                    o.wr   = d_write;
                    o.addr = d_addr;
                    o.data = d_write ? HWDATA : HRDATA;
                    act_q.push_back(o);
                end
                if (!d_write) rd_seen++;
                data_pending = 1'b0;
            end
        end else begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
            HRDATA = $urandom;
            if (HTRANS == 2'b10) begin
                data_pending = 1'b1;
                d_addr       = HADDR;
                d_write      = HWRITE;
                stall_armed  = 1'b0;
                check("hsize", {61'd0, HSIZE}, 64'd2);
                if (HWRITE) begin
                    if (wr_seen == stall_wr_idx) stall_left = stall_len;
                    wr_seen++;
                end
            end
        end
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c,
                            input bit si, input bit di, input int err_idx,
                            input int stall_idx, input int stall_n);
        int  exp_irq;
        int  n_wr;
        int  rd_i;
        int  n;
        bit  err_hit;
        bit  got;
        logic [31:0] ra;

        exp_q.delete();
        act_q.delete();
        rd_i    = 0;
        n_wr    = 0;
        err_hit = 1'b0;
        for (int base = 0; base < int'(c); base += 4) begin
            int len = (int'(c) - base > 4) ? 4 : int'(c) - base;
            for (int k = 0; k < len; k++) begin
                if (rd_i == err_idx) begin
                    err_hit = 1'b1;
                    break;
                end
                ra = s + (si ? 32'(4 * (base + k)) : 32'd0);
                exp_q.push_back({1'b0, ra, mem_word(ra)});
                rd_i++;
            end
            if (err_hit) break;
            for (int k = 0; k < len; k++) begin
                ra = s + (si ? 32'(4 * (base + k)) : 32'd0);
                exp_q.push_back({1'b1, d + (di ? 32'(4 * (base + k)) : 32'd0), mem_word(ra)});
                n_wr++;
            end
        end
        exp_irq = 2 + 2 * exp_q.size() + (err_hit ? 2 : 0)
                + ((stall_idx >= 0 && stall_idx < n_wr) ? stall_n : 0);

        err_read_idx = err_idx;
        stall_wr_idx = stall_idx;
        stall_len    = stall_n;
        rd_seen      = 0;
        wr_seen      = 0;

        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        xfer_cnt   = c;
        src_inc    = si;
        dst_inc    = di;
        Channel_en = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                Channel_en = 1'b0;
                src_addr   = $urandom;
                dst_addr   = $urandom;
                xfer_cnt   = 16'($urandom);
                check("busy_start", {63'd0, busy}, 64'd1);
                check("err_clear", {63'd0, xfer_err}, 64'd0);
            end
            if (n == 3 && c != 16'd0) Channel_en = 1'b1;
            if (n == 4) Channel_en = 1'b0;
            if (irq) got = 1'b1;
            else if (n > 1) check("busy_hold", {63'd0, busy}, 64'd1);
        end
        Channel_en = 1'b0;
        if (!got) begin
            check("irq_timeout", {63'd0, irq}, 64'd1);
        end else begin
            check("irq_cycle", 64'(n), 64'(exp_irq));
            check("busy_at_irq", {63'd0, busy}, 64'd0);
            @(negedge clk);
            check("irq_width", {63'd0, irq}, 64'd0);
            check("xfer_err", {63'd0, xfer_err}, {63'd0, err_hit});
            check("htrans_idle", {62'd0, HTRANS}, 64'd0);
        end
        check("op_count", 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            check("op_dir", {63'd0, act_q[i].wr}, {63'd0, exp_q[i].wr});
            check("op_addr", {32'd0, act_q[i].addr}, {32'd0, exp_q[i].addr});
            if (exp_q[i].wr) check("op_wdata", {32'd0, act_q[i].data}, {32'd0, exp_q[i].data});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"}, {62'd0, HTRANS}, 64'd0);
        check({tag, "_hwrite"}, {63'd0, HWRITE}, 64'd0);
        check({tag, "_hsize"}, {61'd0, HSIZE}, 64'd2);
        check({tag, "_haddr"}, {32'd0, HADDR}, 64'd0);
        check({tag, "_hwdata"}, {32'd0, HWDATA}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_irq"}, {63'd0, irq}, 64'd0);
        check({tag, "_err"}, {63'd0, xfer_err}, 64'd0);
    endtask

    initial begin
        bit saw_irq;
        bit saw_bus;
        seed       = $urandom;
        rst        = 1'b0;
        Channel_en = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        xfer_cnt   = '0;
        src_inc    = 1'b0;
        dst_inc    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b1;
        @(negedge clk);

        run_xfer(32'h0000_1000, 32'h0000_2000, 16'd3, 1'b1, 1'b1, -1, -1, 0);
        run_xfer(32'h0000_1000, 32'h0000_2000, 16'd6, 1'b1, 1'b1, -1, -1, 0);
        run_xfer(32'h0000_4000, 32'h0000_5000, 16'd4, 1'b0, 1'b1, -1, -1, 0);
        run_xfer(32'h0000_1000, 32'h0000_2000, 16'd3, 1'b1, 1'b1, -1, 1, 3);
        run_xfer(32'h0000_6000, 32'h0000_7000, 16'd4, 1'b1, 1'b1, 1, -1, 0);
        run_xfer(32'h0000_1000, 32'h0000_2000, 16'd0, 1'b1, 1'b1, -1, -1, 0);
        run_xfer(32'hFFFF_FFF8, 32'h0000_8000, 16'd5, 1'b1, 1'b0, -1, -1, 0);
        for (int t = 0; t < 8; t++) begin
            run_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                     16'($urandom_range(1, 9)), 1'($urandom), 1'($urandom),
                     -1, (t % 3 == 0) ? int'($urandom_range(0, 3)) : -1,
                     int'($urandom_range(1, 4)));
        end

        // Reset while the first read is in its data phase.
        err_read_idx = -1;
        stall_wr_idx = -1;
        @(negedge clk);
        src_addr   = 32'h0000_3000;
        dst_addr   = 32'h0000_9000;
        xfer_cnt   = 16'd4;
        src_inc    = 1'b1;
        dst_inc    = 1'b1;
        Channel_en = 1'b1;
        @(negedge clk);
        Channel_en = 1'b0;
        @(negedge clk);
        check("rd_data_phase", {62'd0, HTRANS}, 64'd0);
        check("rd_data_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b0;
        #1 check_reset_vals("mid_rst");
        @(negedge clk);
        act_q.delete();
        #1 rst = 1'b1;
        saw_irq = 1'b0;
        saw_bus = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (irq) saw_irq = 1'b1;
            if (HTRANS != 2'b00 || busy) saw_bus = 1'b1;
        end
        check("rst_no_irq", {63'd0, saw_irq}, 64'd0);
        check("rst_no_bus", {63'd0, saw_bus}, 64'd0);
        check("rst_no_ops", 64'(act_q.size()), 64'd0);

        run_xfer(32'h0000_1000, 32'h0000_2000, 16'd2, 1'b1, 1'b1, -1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmac_xfer_engine.md
DMAC_XFER_ENGINE -- requirements
Module: dmac_xfer_engine

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have ports: Channel_en  input  1  one-cycle start pulse from main controller.
REQ-004 SHALL have ports: src_addr, dst_addr  input  32 each  word-aligned start addresses, sampled on start.
REQ-005 SHALL have ports: xfer_cnt  input  16  number of 32-bit words to move, sampled on start.
REQ-006 SHALL have ports: src_inc, dst_inc  input  1 each  1 = address +4 per word, 0 = fixed address.
REQ-007 SHALL have ports: HADDR  output  32;  HTRANS  output  2;  HWRITE  output  1;  HSIZE  output  3;  HWDATA  output  32.
REQ-008 SHALL have ports: HRDATA  input  32;  HREADY  input  1;  HRESP  input  1 (1 = ERROR).
REQ-009 SHALL have ports: busy  output  1  high from the cycle after start until the cycle irq is asserted.
REQ-010 SHALL have ports: irq  output  1  one-cycle completion/abort pulse to main controller;  xfer_err  output  1  sticky bus-error flag.

Function
REQ-011 SHALL implement an FSM with states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
REQ-012 SHALL, in IDLE with Channel_en=1, latch src_addr, dst_addr, xfer_cnt, src_inc, dst_inc, clear xfer_err, and go to RD_ADDR the next cycle; xfer_cnt=0 SHALL go directly to DONE.
REQ-013 SHALL ignore Channel_en in every state other than IDLE.
REQ-014 SHALL move data in chunks of min(4, remaining) words: all chunk reads into a 4-entry buffer first, then all chunk writes.
REQ-015 SHALL, in RD_ADDR/WR_ADDR, drive HTRANS=2'b10 (NONSEQ), HSIZE=3'b010, HADDR=current src/dst address, HWRITE=0/1 respectively; state advances to RD_DATA/WR_DATA only when HREADY=1.
REQ-016 SHALL, in RD_DATA/WR_DATA, drive HTRANS=2'b00 (IDLE); on HREADY=1 with HRESP=0 the word is captured from HRDATA (read) or completed (write, HWDATA held from buffer for the whole data phase).
REQ-017 SHALL, after each completed data phase, step the relevant address by 4 if its inc bit is 1 (32-bit wrap-around, no boundary check) and decrement the chunk count; writes additionally decrement the remaining count.
REQ-018 SHALL, after the last write of a chunk, go to RD_ADDR if remaining>0, else DONE.
REQ-019 SHALL, on HREADY=1 with HRESP=1 in any data state, set xfer_err=1 and go to DONE, abandoning remaining words.
REQ-020 SHALL, in DONE, assert irq=1 for exactly one cycle and return to IDLE the next cycle.
REQ-021 SHALL drive HTRANS=2'b00, HWRITE=0, irq=0 in IDLE and DONE; HADDR/HWDATA are don't-care there but SHALL NOT be X.
REQ-022 SHALL achieve minimum per-word latency of 2 cycles per read and 2 per write with HREADY tied high.

Reset
REQ-023 SHALL, with rst=0, immediately force state IDLE, buffer pointers 0, counters 0, HTRANS=2'b00, HWRITE=0, HSIZE=3'b010, HADDR=0, HWDATA=0, busy=0, irq=0, xfer_err=0.
REQ-024 SHALL, on reset mid-transfer, abandon the transfer without asserting irq; no further bus activity until a new Channel_en.

Structure
REQ-025 SHALL place the state enum, HTRANS encodings (IDLE/NONSEQ), HSIZE_WORD and BUF_DEPTH=4 in shared package dmac_pkg.
REQ-026 SHALL instantiate one sub-module dmac_xfer_buf: 4x32 buffer with write pointer, read pointer, clear, and count.

Verification
REQ-027 SHALL cover: src=0x1000, dst=0x2000, cnt=3, inc both, HREADY=1 -> reads 0x1000/04/08, then writes 0x2000/04/08 with matching data, irq pulse at cycle 14 after start.
REQ-028 SHALL cover: cnt=6 -> two chunks (4 reads, 4 writes, 2 reads, 2 writes), exactly 6 writes, one irq.
REQ-029 SHALL cover: src_inc=0, dst_inc=1, cnt=4 -> all reads to same address, writes to 4 consecutive words.
REQ-030 SHALL cover: HREADY=0 for 3 cycles in WR_DATA of word 2 -> HWDATA and state stable, transfer completes 3 cycles later.
REQ-031 SHALL cover: HRESP=1 on read 2 of cnt=4 -> xfer_err=1, irq pulse, no write issued.
REQ-032 SHALL cover: cnt=0 -> irq two cycles after start, no bus activity; and rst=0 during RD_DATA -> outputs at reset values same cycle, no irq.
